line_buffer_ctrl: RTL

Frame sequencer for the 3x3 sliding-window line buffer feeding the VGG-16 convolution engine. Accepts an unpadded IMG_W x IMG_W pixel stream over a valid/ready handshake, inserts the one-pixel zero border, and drives the line buffer's push strobe and pixel input. Tracks the padded row/column position and flags each cycle in which the line buffer's nine window registers hold a complete in-image 3x3 window, with output coordinates. Sits between the input feature-map reader and the line buffer / MAC array.

---
 rtl/line_buffer_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3x3 line buffer: adds the zero border around an IMG_W x IMG_W
// raster stream, drives the push strobe, and tracks which pushes complete an in-image window.
module line_buffer_ctrl #(
  parameter int IMG_W  = 224,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       lb_shift,
  output logic [DATA_W-1:0]          lb_pixel,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [$clog2(IMG_W)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       done
);

  localparam int PW = IMG_W + 2;
  localparam int CW = $clog2(PW);
  localparam int OW = $clog2(IMG_W);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   r_q, r_d, c_q, c_d;
  logic            pend_q, pend_d;
  logic [OW-1:0]   pend_row_q, pend_row_d, pend_col_q, pend_col_d;
  logic            win_valid_q, win_valid_d;
  logic [OW-1:0]   win_row_q, win_row_d, win_col_q, win_col_d;
  logic            done_q, done_d;

  logic can_go, border;

  // A push is only allowed once the window currently shown has been taken,
  // otherwise the line buffer would overwrite it.
  assign can_go = !win_valid_q || win_ready;
  assign border = (r_q == '0) || (r_q == LAST) || (c_q == '0) || (c_q == LAST);

  always_comb begin
    in_ready = 1'b0;
    lb_shift = 1'b0;
    lb_pixel = '0;
    case (state_q)
      STREAM: begin
        if (border) begin
          lb_shift = can_go;
        end else begin
          in_ready = can_go;
          lb_shift = in_valid && can_go;
          lb_pixel = in_data;
        end
      end
      FLUSH:   lb_shift = can_go;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    pend_col_d  = pend_col_q;
    win_valid_d = win_valid_q && !win_ready;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = 1'b0;

    if (state_q == IDLE && start) begin
      state_d = STREAM;
      r_d     = '0;
      c_d     = '0;
    end

    if (lb_shift) begin
      // The window completed by the previous push lands in the window registers now.
      win_valid_d = pend_q;
      if (pend_q) begin
        win_row_d = pend_row_q;
        win_col_d = pend_col_q;
      end
      if (state_q == STREAM) begin
        pend_d     = (r_q >= TWO) && (c_q >= TWO);
        pend_row_d = OW'(r_q - TWO);
        pend_col_d = OW'(c_q - TWO);
        if (r_q == LAST && c_q == LAST) begin
          state_d = FLUSH;
          r_d     = '0;
          c_d     = '0;
        end else if (c_q == LAST) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end else begin
        pend_d  = 1'b0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      pend_q      <= 1'b0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      pend_q      <= pend_d;
      pend_row_q  <= pend_row_d;
      pend_col_q  <= pend_col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
